debounce_ctrl: RTL and testbench

- Cleans a raw, asynchronous, bouncing input (push-button or switch) into a stable level.
- Generates single-cycle edge strobes alongside the level.
- Sits directly upstream of the team's D latch: `db_out` drives the latch data input and `en_pulse` drives the latch enable, so the latch only captures settled values.
- Contains a synchronizer chain, a stability counter and a 4-state FSM.

---
 rtl/debounce_pkg.sv | 21 ++
 rtl/sync_chain.sv | 29 ++
 rtl/debounce_ctrl.sv | 138 +++++++++++++
 tb/tb_debounce_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce controller and its synchronizer.
// Holds the FSM state encodings and default parameters.
package debounce_pkg;

   localparam int DEF_SYNC_STAGES   = 2;
   localparam int DEF_STABLE_CYCLES = 10;
   localparam int DEF_CNT_W         = 4;

   typedef logic [1:0] state_t;

   // Fixed encodings; the two wait states sit next to their settled state.
   localparam state_t S_LOW       = 2'b00;
   localparam state_t S_RISE_WAIT = 2'b01;
   localparam state_t S_HIGH      = 2'b10;
   localparam state_t S_FALL_WAIT = 2'b11;

   function automatic state_t reset_state(input bit level);
      return level ? S_HIGH : S_LOW;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchronizer for one asynchronous input.
// No logic sits between the flops, so the chain stays metastability-safe.
module sync_chain #(
   parameter int SYNC_STAGES = 2,
   parameter bit RESET_LEVEL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic sync_out
);

   logic [SYNC_STAGES-1:0] stages;

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $fatal(1, "sync_chain: SYNC_STAGES must be in 2..4");
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stages <= {SYNC_STAGES{RESET_LEVEL}};
      end else begin
         stages <= {stages[SYNC_STAGES-2:0], din};
      end
   end

   assign sync_out = stages[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_ctrl.sv
// Debounces a raw asynchronous input into a registered level plus edge strobes.
// en_pulse feeds the downstream latch enable so it only captures settled values.
module debounce_ctrl
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int CNT_W         = DEF_CNT_W,
   parameter bit RESET_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_in,
   output logic db_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic en_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam bit               BYPASS   = (STABLE_CYCLES == 1);

   if (STABLE_CYCLES < 1 || STABLE_CYCLES >= (1 << CNT_W)) begin : g_bad_stable
      $fatal(1, "debounce_ctrl: STABLE_CYCLES must be in 1..2**CNT_W-1");
   end

   logic             sync_in;
   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             db_nxt;
   logic             rise_nxt;
   logic             fall_nxt;

   sync_chain #(
      .SYNC_STAGES (SYNC_STAGES),
      .RESET_LEVEL (RESET_LEVEL)
   ) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .din      (raw_in),
      .sync_out (sync_in)
   );

   // A wait state counts how long sync_in has held the new level; any return
   // to the old level drops straight back and clears the count.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      db_nxt    = db_out;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
         S_LOW: begin
            if (sync_in) begin
               if (BYPASS) begin
                  state_nxt = S_HIGH;
                  db_nxt    = 1'b1;
                  rise_nxt  = 1'b1;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = S_RISE_WAIT;
                  cnt_nxt   = CNT_ONE;
               end
            end else begin
               cnt_nxt = '0;
            end
         end
         S_RISE_WAIT: begin
            if (!sync_in) begin
               state_nxt = S_LOW;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_HIGH;
               db_nxt    = 1'b1;
               rise_nxt  = 1'b1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         S_HIGH: begin
            if (!sync_in) begin
               if (BYPASS) begin
                  state_nxt = S_LOW;
                  db_nxt    = 1'b0;
                  fall_nxt  = 1'b1;
                  cnt_nxt   = '0;
               end else begin
                  state_nxt = S_FALL_WAIT;
                  cnt_nxt   = CNT_ONE;
               end
            end else begin
               cnt_nxt = '0;
            end
         end
         S_FALL_WAIT: begin
            if (sync_in) begin
               state_nxt = S_HIGH;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = S_LOW;
               db_nxt    = 1'b0;
               fall_nxt  = 1'b1;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = reset_state(RESET_LEVEL);
            cnt_nxt   = '0;
         end
      endcase
   end

   // Every output is a flop, so raw_in never reaches an output combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= reset_state(RESET_LEVEL);
         cnt        <= '0;
         db_out     <= RESET_LEVEL;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         en_pulse   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         db_out     <= db_nxt;
         rise_pulse <= rise_nxt;
         fall_pulse <= fall_nxt;
         en_pulse   <= rise_nxt | fall_nxt;
      end
   end

endmodule

// File: tb/tb_debounce_ctrl.sv
// Directed bench for debounce_ctrl: default build plus a STABLE_CYCLES = 1 build.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_debounce_ctrl;
   import debounce_pkg::*;

   logic clk;
   logic rst_n;
   logic raw_in;
   logic db_out, rise_pulse, fall_pulse, en_pulse;
   logic raw_b;
   logic db_b, rise_b, fall_b, en_b;

   int checks = 0;
   int errors = 0;

   debounce_ctrl u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_in     (raw_in),
      .db_out     (db_out),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .en_pulse   (en_pulse)
   );

   debounce_ctrl #(.STABLE_CYCLES(1)) u_dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .raw_in     (raw_b),
      .db_out     (db_b),
      .rise_pulse (rise_b),
      .fall_pulse (fall_b),
      .en_pulse   (en_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Compares all four outputs of the default DUT against one expectation.
   task automatic expect_main(input string tag, input int e,
                              input logic xdb, input logic xr, input logic xf);
      checks++;
      if ({db_out, rise_pulse, fall_pulse, en_pulse} !== {xdb, xr, xf, xr | xf}) begin
         errors++;
         $display("[TB] FAIL %s edge %0d: got db/rise/fall/en=%b%b%b%b expected %b%b%b%b",
                  tag, e, db_out, rise_pulse, fall_pulse, en_pulse, xdb, xr, xf, xr | xf);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      raw_in = 1'b0;
      raw_b = 1'b0;
      #1;
      for (int e = 1; e <= 6; e++) begin
         raw_in = e[0];
         raw_b = ~e[0];
         step();
         expect_main("reset_hold", e, 1'b0, 1'b0, 1'b0);
         checks++;
         if ({db_b, rise_b, fall_b, en_b} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_hold_b edge %0d: got %b%b%b%b expected 0000",
                     e, db_b, rise_b, fall_b, en_b);
         end
      end
      raw_in = 1'b0;
      raw_b = 1'b0;
      step();
      rst_n = 1'b1;
      for (int e = 1; e <= 20; e++) begin
         step();
         expect_main("reset_idle", e, 1'b0, 1'b0, 1'b0);
      end
   endtask

   task automatic test_clean_rise();
      for (int e = 1; e <= 14; e++) begin
         raw_in = 1'b1;
         step();
         expect_main("clean_rise", e, (e >= 12), (e == 12), 1'b0);
      end
   endtask

   task automatic test_falling();
      for (int e = 1; e <= 14; e++) begin
         raw_in = 1'b0;
         step();
         expect_main("falling", e, (e < 12), 1'b0, (e == 12));
      end
   endtask

   task automatic test_glitch();
      for (int e = 1; e <= 20; e++) begin
         raw_in = (e <= 5);
         step();
         expect_main("glitch", e, 1'b0, 1'b0, 1'b0);
      end
      checks++;
      if (u_dut.cnt !== 4'd0 || u_dut.state !== S_LOW) begin
         errors++;
         $display("[TB] FAIL glitch_cnt: got cnt=%0d state=%b expected cnt=0 state=%b",
                  u_dut.cnt, u_dut.state, S_LOW);
      end
   endtask

   // sync_in is seen high for 9 cycles, low for one, then high for good.
   task automatic test_near_threshold();
      for (int e = 1; e <= 24; e++) begin
         raw_in = (e <= 9 || e >= 11);
         step();
         expect_main("near_thresh", e, (e >= 22), (e == 22), 1'b0);
         if (e == 12) begin
            checks++;
            if (u_dut.cnt !== 4'd0 || u_dut.state !== S_LOW) begin
               errors++;
               $display("[TB] FAIL near_thresh_clear: got cnt=%0d state=%b expected cnt=0 state=%b",
                        u_dut.cnt, u_dut.state, S_LOW);
            end
         end
      end
   endtask

   task automatic test_reset_mid_wait();
      // Pending fall one edge before it would fire.
      raw_in = 1'b0;
      repeat (11) step();
      checks++;
      if (u_dut.state !== S_FALL_WAIT || db_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midwait_pre_fall: got state=%b db=%b expected state=%b db=1",
                  u_dut.state, db_out, S_FALL_WAIT);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({db_out, rise_pulse, fall_pulse, en_pulse} !== 4'b0000 || u_dut.state !== S_LOW) begin
         errors++;
         $display("[TB] FAIL midwait_async_clear: got db/rise/fall/en=%b%b%b%b state=%b expected 0000 state=%b",
                  db_out, rise_pulse, fall_pulse, en_pulse, u_dut.state, S_LOW);
      end
      step();
      expect_main("midwait_fall_suppressed", 12, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;

      // Reset landing inside the rise wait.
      raw_in = 1'b1;
      repeat (8) step();
      checks++;
      if (u_dut.state !== S_RISE_WAIT || u_dut.cnt !== 4'd6) begin
         errors++;
         $display("[TB] FAIL midwait_pre_rise: got state=%b cnt=%0d expected state=%b cnt=6",
                  u_dut.state, u_dut.cnt, S_RISE_WAIT);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (u_dut.cnt !== 4'd0 || u_dut.state !== S_LOW || db_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midwait_rise_clear: got cnt=%0d state=%b db=%b expected cnt=0 state=%b db=0",
                  u_dut.cnt, u_dut.state, db_out, S_LOW);
      end
      step();
      expect_main("midwait_rise_in_reset", 0, 1'b0, 1'b0, 1'b0);

      // First edge after release is an ordinary cycle from the reset state.
      rst_n = 1'b1;
      for (int e = 1; e <= 13; e++) begin
         step();
         expect_main("after_release", e, (e >= 12), (e == 12), 1'b0);
      end
   endtask

   // Hand-built vectors, bit index = edge number; db follows raw two edges later.
   task automatic test_single_cycle();
      logic [14:1] raw_vec  = 14'b00000111001011;
      logic [14:1] db_vec   = 14'b00011100101100;
      logic [14:1] rise_vec = 14'b00000100100100;
      logic [14:1] fall_vec = 14'b00100001010000;
      for (int e = 1; e <= 14; e++) begin
         raw_b = raw_vec[e];
         step();
         checks++;
         if ({db_b, rise_b, fall_b, en_b} !==
             {db_vec[e], rise_vec[e], fall_vec[e], rise_vec[e] | fall_vec[e]}) begin
            errors++;
            $display("[TB] FAIL stable1 edge %0d: got db/rise/fall/en=%b%b%b%b expected %b%b%b%b",
                     e, db_b, rise_b, fall_b, en_b,
                     db_vec[e], rise_vec[e], fall_vec[e], rise_vec[e] | fall_vec[e]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_clean_rise();
      test_falling();
      test_glitch();
      test_near_threshold();
      test_reset_mid_wait();
      test_single_cycle();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
